// File: rtl/window_fetch.sv
// Window fetch: turns one window origin into SWEEP_X x SWEEP_Y row-major RAM reads
// and streams the returned pixels through a 2-entry skid FIFO with valid/ready.
module window_fetch #(
  parameter int IMG_WIDTH  = 41,
  parameter int IMG_HEIGHT = 50,
  parameter int SWEEP_X    = 24,
  parameter int SWEEP_Y    = 24,
  parameter int DATA_W     = 8,
  localparam int W_X  = $clog2(IMG_WIDTH),
  localparam int W_Y  = $clog2(IMG_HEIGHT),
  localparam int W_A  = $clog2(IMG_WIDTH * IMG_HEIGHT),
  localparam int W_WX = $clog2(SWEEP_X),
  localparam int W_WY = $clog2(SWEEP_Y)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hop_valid,
  output logic              hop_ready,
  input  logic [W_X-1:0]    x_hop,
  input  logic [W_Y-1:0]    y_hop,
  output logic              hop_err,
  output logic              mem_rd,
  output logic [W_A-1:0]    mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic [W_WX-1:0]   pix_wx,
  output logic [W_WY-1:0]   pix_wy,
  output logic              pix_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [W_X-1:0]  X_MAX    = W_X'(IMG_WIDTH - SWEEP_X);
  localparam logic [W_Y-1:0]  Y_MAX    = W_Y'(IMG_HEIGHT - SWEEP_Y);
  localparam logic [W_WX-1:0] WX_LAST  = W_WX'(SWEEP_X - 1);
  localparam logic [W_WY-1:0] WY_LAST  = W_WY'(SWEEP_Y - 1);
  localparam logic [W_A-1:0]  A_STRIDE = W_A'(IMG_WIDTH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [W_WX-1:0]   wx;
    logic [W_WY-1:0]   wy;
    logic              last;
  } pix_t;

  logic [1:0]      r_state;
  logic [W_X-1:0]  r_base_x;
  logic [W_Y-1:0]  r_base_y;
  logic [W_WX-1:0] r_wx;
  logic [W_WY-1:0] r_wy;
  logic            r_hop_err;
  logic            r_inflight;
  logic [W_WX-1:0] r_inf_wx;
  logic [W_WY-1:0] r_inf_wy;
  logic            r_inf_last;
  pix_t            r_fifo [2];
  logic            r_rd_ptr;
  logic            r_wr_ptr;
  logic [1:0]      r_count;

  logic       w_accept;
  logic       w_range_bad;
  logic       w_pop;
  logic [2:0] w_occ;
  logic       w_issue;
  logic       w_wx_end;
  logic       w_wy_end;
  pix_t       w_head;

  assign hop_ready   = (r_state == S_IDLE);
  assign hop_err     = r_hop_err;
  assign w_accept    = hop_valid && hop_ready;
  assign w_range_bad = (x_hop > X_MAX) || (y_hop > Y_MAX);

  // Occupancy after this cycle's pop, counting the read still in flight;
  // issuing only below 2 keeps the FIFO from overflowing.
  assign w_pop   = pix_valid && pix_ready;
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_state == S_FETCH) && (w_occ < 3'd2);

  assign w_wx_end = (r_wx == WX_LAST);
  assign w_wy_end = (r_wy == WY_LAST);

  assign mem_rd   = w_issue;
  assign mem_addr = (W_A'(r_base_y) + W_A'(r_wy)) * A_STRIDE
                  + W_A'(r_base_x) + W_A'(r_wx);

  assign w_head    = r_fifo[r_rd_ptr];
  assign pix_valid = (r_count != 2'd0);
  assign pix_data  = pix_valid ? w_head.data : '0;
  assign pix_wx    = pix_valid ? w_head.wx   : '0;
  assign pix_wy    = pix_valid ? w_head.wy   : '0;
  assign pix_last  = pix_valid && w_head.last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_base_x   <= '0;
      r_base_y   <= '0;
      r_wx       <= '0;
      r_wy       <= '0;
      r_hop_err  <= 1'b0;
      r_inflight <= 1'b0;
      r_inf_wx   <= '0;
      r_inf_wy   <= '0;
      r_inf_last <= 1'b0;
      r_fifo[0]  <= '0;
      r_fifo[1]  <= '0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_hop_err <= w_accept && w_range_bad;

      case (r_state)
        S_IDLE: begin
          if (w_accept && !w_range_bad) begin
            r_base_x <= x_hop;
            r_base_y <= y_hop;
            r_wx     <= '0;
            r_wy     <= '0;
            r_state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_issue) begin
            if (w_wx_end) begin
              r_wx <= '0;
              if (w_wy_end) r_state <= S_DRAIN;
              else          r_wy    <= r_wy + 1'b1;
            end else begin
              r_wx <= r_wx + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_pop && w_head.last) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Window coordinates ride alongside the read so they pair with the returned data.
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inf_wx   <= r_wx;
        r_inf_wy   <= r_wy;
        r_inf_last <= w_wx_end && w_wy_end;
      end

      if (r_inflight) begin
        r_fifo[r_wr_ptr].data <= mem_data;
        r_fifo[r_wr_ptr].wx   <= r_inf_wx;
        r_fifo[r_wr_ptr].wy   <= r_inf_wy;
        r_fifo[r_wr_ptr].last <= r_inf_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

endmodule
